// File: rtl/p4_router_ingress_dwrr_scheduler.sv
// Deficit-weighted round-robin scheduler for the P4 router ingress buffer
// read side. Each partition reports whether a complete packet is present and
// the byte length of its head packet; the scheduler hands out one packet
// grant at a time to the buffer read controller. Each partition is served in
// proportion to its byte quantum.
module p4_router_ingress_dwrr_scheduler #(
    parameter int NUM_PORTS      = 4,
    parameter int QUANTUM_WIDTH  = 16,
    parameter int BYTE_LEN_WIDTH = 11,
    parameter int DEFICIT_WIDTH  = QUANTUM_WIDTH + 1,
    localparam int PORT_W        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                                clk,
    input  logic                                areset,
    input  logic [NUM_PORTS-1:0]                port_pkt_avail,
    input  logic [NUM_PORTS*BYTE_LEN_WIDTH-1:0] port_head_byte_length,
    input  logic [NUM_PORTS*QUANTUM_WIDTH-1:0]  port_quantum,
    output logic                                grant_valid,
    input  logic                                grant_ready,
    output logic [PORT_W-1:0]                   grant_port,
    output logic [BYTE_LEN_WIDTH-1:0]           grant_byte_length,
    input  logic                                pkt_done,
    output logic                                protocol_err
);

    typedef enum logic [1:0] {
        ST_SCAN  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    // Per-port views of the packed input buses.
    logic [NUM_PORTS-1:0][BYTE_LEN_WIDTH-1:0] head_len;
    logic [NUM_PORTS-1:0][QUANTUM_WIDTH-1:0]  quantum;

    assign head_len = port_head_byte_length;
    assign quantum  = port_quantum;

    // Scheduler state.
    state_t                                  state_q, state_d;
    logic [PORT_W-1:0]                       ptr_q, ptr_d;
    logic [NUM_PORTS-1:0][DEFICIT_WIDTH-1:0] deficit_q, deficit_d;
    logic [NUM_PORTS-1:0]                    visited_q, visited_d;
    logic                                    grant_valid_q, grant_valid_d;
    logic [PORT_W-1:0]                       grant_port_q, grant_port_d;
    logic [BYTE_LEN_WIDTH-1:0]               grant_len_q, grant_len_d;
    logic                                    proto_err_q, proto_err_d;

    // Values of the port currently under the scan pointer.
    logic                      cur_avail;
    logic [BYTE_LEN_WIDTH-1:0] cur_len;
    logic [QUANTUM_WIDTH-1:0]  cur_quantum;
    logic [DEFICIT_WIDTH-1:0]  cur_deficit;

    assign cur_avail   = port_pkt_avail[ptr_q];
    assign cur_len     = head_len[ptr_q];
    assign cur_quantum = quantum[ptr_q];
    assign cur_deficit = deficit_q[ptr_q];

    // Add a quantum to a deficit, clamping at the all-ones value instead of wrapping.
    function automatic logic [DEFICIT_WIDTH-1:0] sat_add(
        input logic [DEFICIT_WIDTH-1:0] a,
        input logic [QUANTUM_WIDTH-1:0] b
    );
        logic [DEFICIT_WIDTH:0] sum;
        sum = {1'b0, a} + (DEFICIT_WIDTH + 1)'(b);
        if (sum[DEFICIT_WIDTH]) begin
            return '1;
        end
        return sum[DEFICIT_WIDTH-1:0];
    endfunction

    // Advance the scan pointer, wrapping from the last port back to port 0.
    function automatic logic [PORT_W-1:0] ptr_inc(input logic [PORT_W-1:0] p);
        if (p == PORT_W'(NUM_PORTS - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Next-state logic: one DWRR decision per cycle while scanning.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        deficit_d     = deficit_q;
        visited_d     = visited_q;
        grant_valid_d = grant_valid_q;
        grant_port_d  = grant_port_q;
        grant_len_d   = grant_len_q;
        // A done pulse is only meaningful while a packet is streaming; any
        // other pulse (including in the accept cycle) is a sticky error.
        proto_err_d   = proto_err_q | (pkt_done && (state_q != ST_BUSY));

        case (state_q)
            ST_SCAN: begin
                if ((cur_quantum == '0) || !cur_avail) begin
                    // Idle or disabled ports forfeit any accumulated credit.
                    deficit_d[ptr_q] = '0;
                    visited_d[ptr_q] = 1'b0;
                    ptr_d            = ptr_inc(ptr_q);
                end else if (!visited_q[ptr_q]) begin
                    // First look at this port in the round: top up its credit.
                    deficit_d[ptr_q] = sat_add(cur_deficit, cur_quantum);
                    visited_d[ptr_q] = 1'b1;
                end else if (cur_deficit >= DEFICIT_WIDTH'(cur_len)) begin
                    grant_port_d  = ptr_q;
                    grant_len_d   = cur_len;
                    grant_valid_d = 1'b1;
                    state_d       = ST_GRANT;
                end else begin
                    // Credit too small for the head packet: keep it for next round.
                    visited_d[ptr_q] = 1'b0;
                    ptr_d            = ptr_inc(ptr_q);
                end
            end

            ST_GRANT: begin
                if (grant_ready) begin
                    // The compare that issued this grant guarantees no underflow.
                    deficit_d[ptr_q] = deficit_q[ptr_q] - DEFICIT_WIDTH'(grant_len_q);
                    grant_valid_d    = 1'b0;
                    state_d          = ST_BUSY;
                end
            end

            ST_BUSY: begin
                // Pointer and visited flag are kept so the same port is
                // re-examined against its new head packet.
                if (pkt_done) begin
                    state_d = ST_SCAN;
                end
            end

            default: begin
                state_d       = ST_SCAN;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset drops any outstanding grant without a handshake.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q       <= ST_SCAN;
            ptr_q         <= '0;
            deficit_q     <= '0;
            visited_q     <= '0;
            grant_valid_q <= 1'b0;
            grant_port_q  <= '0;
            grant_len_q   <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            deficit_q     <= deficit_d;
            visited_q     <= visited_d;
            grant_valid_q <= grant_valid_d;
            grant_port_q  <= grant_port_d;
            grant_len_q   <= grant_len_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign grant_valid       = grant_valid_q;
    assign grant_port        = grant_port_q;
    assign grant_byte_length = grant_len_q;
    assign protocol_err      = proto_err_q;

endmodule

// File: tb/tb_p4_router_ingress_dwrr_scheduler.sv
// Scoreboard bench for the ingress DWRR scheduler: directed port setups push
// the hand-derived grant sequence into a queue, a monitor pops and compares
// every accepted grant (port, length, and spacing where it is meaningful).
module tb_p4_router_ingress_dwrr_scheduler;

    localparam int NP = 4;
    localparam int QW = 16;
    localparam int LW = 11;
    localparam int PW = 2;

    logic                   clk = 1'b0;
    logic                   areset;
    logic [NP-1:0]          avail;
    logic [NP-1:0][LW-1:0]  hlen;
    logic [NP-1:0][QW-1:0]  quant;
    logic                   grant_ready;
    logic                   pkt_done;
    logic                   grant_valid;
    logic [PW-1:0]          grant_port;
    logic [LW-1:0]          grant_byte_length;
    logic                   protocol_err;

    p4_router_ingress_dwrr_scheduler #(
        .NUM_PORTS      (NP),
        .QUANTUM_WIDTH  (QW),
        .BYTE_LEN_WIDTH (LW)
    ) dut (
        .clk                   (clk),
        .areset                (areset),
        .port_pkt_avail        (avail),
        .port_head_byte_length (hlen),
        .port_quantum          (quant),
        .grant_valid           (grant_valid),
        .grant_ready           (grant_ready),
        .grant_port            (grant_port),
        .grant_byte_length     (grant_byte_length),
        .pkt_done              (pkt_done),
        .protocol_err          (protocol_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [PW-1:0] port;
        logic [LW-1:0] blen;
        int            gap;   // cycles since previous accept; 0 = not checked
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input int port, input int blen, input int gap);
        exp_t e;
        e.port = PW'(port);
        e.blen = LW'(blen);
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted grant is compared with the head of the scoreboard.
    initial begin
        exp_t e;
        int   last;
        last = 0;
        forever begin
            @(negedge clk);
            #2;
            if (grant_valid === 1'b1 && grant_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_grant: got port %0d len %0d, expected no grant",
                             grant_port, grant_byte_length);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_port", 32'(grant_port), 32'(e.port));
                    check("grant_len", 32'(grant_byte_length), 32'(e.blen));
                    if (e.gap != 0) check("grant_gap", cyc - last, e.gap);
                end
                last = cyc;
            end
        end
    end

    // Wait (bounded) for the scheduler to offer a grant; returns at a negedge.
    task automatic wait_grant(output bit ok);
        int k;
        k  = 0;
        ok = 1'b1;
        forever begin
            @(negedge clk);
            if (grant_valid === 1'b1) break;
            k++;
            if (k > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL grant_timeout: got no grant_valid in 200 cycles, expected a grant");
                ok = 1'b0;
                break;
            end
        end
    endtask

    // Read controller model: accept n grants, each followed by a one-cycle done.
    task automatic serve(input int n);
        bit ok;
        for (int i = 0; i < n; i++) begin
            wait_grant(ok);
            if (!ok) return;
            grant_ready = 1'b1;
            @(posedge clk);
            #1;
            grant_ready = 1'b0;
            pkt_done    = 1'b1;
            @(posedge clk);
            #1;
            pkt_done    = 1'b0;
        end
    endtask

    task automatic reset_assert();
        @(negedge clk);
        areset = 1'b1;
        #1;
        check("rst_grant_valid", 32'(grant_valid), 0);
        check("rst_grant_port", 32'(grant_port), 0);
        check("rst_grant_len", 32'(grant_byte_length), 0);
        check("rst_protocol_err", 32'(protocol_err), 0);
    endtask

    task automatic reset_release();
        @(negedge clk);
        areset = 1'b0;
    endtask

    task automatic phase_end(input string name);
        check({name, "_scoreboard_empty"}, exp_q.size(), 0);
        check({name, "_protocol_err"}, 32'(protocol_err), 0);
    endtask

    task automatic clear_ports();
        avail = '0;
        hlen  = '0;
        quant = '0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        areset      = 1'b1;
        grant_ready = 1'b0;
        pkt_done    = 1'b0;
        clear_ports();
        repeat (2) @(posedge clk);
        reset_assert();

        // Only port 0: quantum 1500, 64-byte packets -> 23, 23, 24 grants per visit.
        avail[0] = 1'b1; quant[0] = 16'd1500; hlen[0] = 11'd64;
        reset_release();
        @(posedge clk); #1;
        check("latency_add_cycle", 32'(grant_valid), 0);
        @(posedge clk); #1;
        check("latency_compare_cycle", 32'(grant_valid), 1);
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < ((v == 2) ? 24 : 23); i++) begin
                push(0, 64, (i != 0) ? 3 : ((v == 0) ? 0 : 8));
            end
        end
        serve(70);
        phase_end("single_port");
        wait_grant(ok);
        reset_assert();   // dropped mid-GRANT: outputs must clear at once

        // Ports 0/1 quantum 1000, 1500-byte vs 100-byte packets.
        clear_ports();
        avail = 4'b0011; quant[0] = 16'd1000; quant[1] = 16'd1000;
        hlen[0] = 11'd1500; hlen[1] = 11'd100;
        reset_release();
        for (int r = 0; r < 6; r++) begin
            if (r % 3 != 0) push(0, 1500, 0);
            for (int i = 0; i < 10; i++) push(1, 100, 0);
        end
        serve(64);
        phase_end("byte_fair");
        reset_assert();

        // Ports 2/3 quantum 3000/1000, 500-byte packets -> 6:2 per round.
        clear_ports();
        avail = 4'b1100; quant[2] = 16'd3000; quant[3] = 16'd1000;
        hlen[2] = 11'd500; hlen[3] = 11'd500;
        reset_release();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 6; i++) push(2, 500, 0);
            for (int i = 0; i < 2; i++) push(3, 500, 0);
        end
        serve(32);
        phase_end("weighted");
        wait_grant(ok);
        push(2, 500, 0);
        grant_ready = 1'b1;
        @(posedge clk); #1;
        grant_ready = 1'b0;
        @(posedge clk); #1;
        check("busy_grant_valid", 32'(grant_valid), 0);
        check("busy_scoreboard_empty", exp_q.size(), 0);
        reset_assert();   // dropped mid-BUSY

        // Port 0 disabled by quantum 0; ports 1..3 quantum 1500, 700-byte.
        clear_ports();
        avail = 4'b1111; hlen[0] = 11'd100;
        for (int p = 1; p < NP; p++) begin
            quant[p] = 16'd1500;
            hlen[p]  = 11'd700;
        end
        reset_release();
        wait_grant(ok);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(grant_valid), 1);
            check("stall_port", 32'(grant_port), 1);
            check("stall_len", 32'(grant_byte_length), 700);
        end
        for (int r = 0; r < 2; r++) begin
            for (int p = 1; p < NP; p++) begin
                push(p, 700, 0);
                push(p, 700, 0);
            end
        end
        serve(12);
        phase_end("quantum_zero");
        reset_assert();

        // Port 1 loses its packet after one grant; its residual credit must be dropped.
        clear_ports();
        avail[1] = 1'b1; quant[1] = 16'd1000; hlen[1] = 11'd64;
        reset_release();
        push(1, 64, 0);
        serve(1);
        avail[1] = 1'b0;
        hlen[1]  = 11'd1500;
        repeat (5) @(posedge clk);
        #1;
        avail    = 4'b0011;
        quant[0] = 16'd500;
        hlen[0]  = 11'd500;
        push(0, 500, 0); push(0, 500, 0); push(1, 1500, 0); push(0, 500, 0);
        push(1, 1500, 0); push(0, 500, 0); push(0, 500, 0); push(1, 1500, 0);
        serve(8);
        phase_end("avail_drop");
        reset_assert();

        // Zero-length head packets are granted back to back without credit loss.
        clear_ports();
        avail[3] = 1'b1; quant[3] = 16'd1; hlen[3] = 11'd0;
        reset_release();
        push(3, 0, 0); push(3, 0, 3); push(3, 0, 3); push(3, 0, 3);
        serve(4);
        phase_end("zero_len");
        reset_assert();

        // Stray done pulse while scanning with nothing pending.
        clear_ports();
        reset_release();
        repeat (3) @(negedge clk);
        check("err_before_pulse", 32'(protocol_err), 0);
        pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
        #1;
        check("err_after_pulse", 32'(protocol_err), 1);
        check("err_no_grant", 32'(grant_valid), 0);
        repeat (10) @(negedge clk);
        check("err_sticky", 32'(protocol_err), 1);
        check("err_still_no_grant", 32'(grant_valid), 0);
        check("final_scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
